// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared types for the sequential parametrised ALU:
//   alu_op_e    - 4-bit opcode encoding (12..15 reserved)
//   FLAG_*      - bit positions of {Z,N,C,V} inside the 4-bit flag vector
//   alu_state_e - handshake FSM states
//   pack_flags  - builds the flag vector from individual flag bits
// ---------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ZERO  = 4'd0,
    OP_ADD   = 4'd1,
    OP_SUB   = 4'd2,
    OP_PASSA = 4'd3,
    OP_XOR   = 4'd4,
    OP_OR    = 4'd5,
    OP_AND   = 4'd6,
    OP_INC   = 4'd7,
    OP_MUL   = 4'd8,
    OP_SHL   = 4'd9,
    OP_SHR   = 4'd10,
    OP_SAR   = 4'd11,
    OP_RSV12 = 4'd12,
    OP_RSV13 = 4'd13,
    OP_RSV14 = 4'd14,
    OP_RSV15 = 4'd15
  } alu_op_e;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } alu_state_e;

  // Place individual flag bits at their architectural positions.
  function automatic logic [3:0] pack_flags(input logic z, input logic n,
                                            input logic c, input logic v);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_shift_add_mul.sv
// ---------------------------------------------------------------------------
// alu_shift_add_mul
// Iterative unsigned shift-add multiplier. One partial product is folded in
// per clock; the first one is folded in on the Start edge itself, so the full
// 2*WIDTH product is registered WIDTH edges after Start (including the Start
// edge) and o_done pulses for one cycle right after that.
// Ports:
//   i_clk      clock, rising edge
//   i_reset    synchronous active-high reset; abandons a multiply in flight
//   i_start    one-cycle pulse: capture i_a/i_b and begin
//   i_a, i_b   WIDTH-bit unsigned operands
//   o_product  2*WIDTH-bit product, valid while o_done is high and after
//   o_done     one-cycle pulse when o_product is complete
// ---------------------------------------------------------------------------
module alu_shift_add_mul
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic [2*WIDTH-1:0]   o_product,
  output logic                 o_done
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_prod;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [2*WIDTH-1:0] w_addend;

  // Partial product selected by the current multiplier LSB.
  assign w_addend = r_mplier[0] ? r_mcand : {(2*WIDTH){1'b0}};

  // Load on start (with first partial product), then iterate WIDTH-1 times.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mcand  <= {(2*WIDTH){1'b0}};
      r_mplier <= {WIDTH{1'b0}};
      r_prod   <= {(2*WIDTH){1'b0}};
      r_cnt    <= {CNT_W{1'b0}};
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= {{(WIDTH-1){1'b0}}, i_a, 1'b0};
      r_mplier <= {1'b0, i_b[WIDTH-1:1]};
      r_prod   <= i_b[0] ? {{WIDTH{1'b0}}, i_a} : {(2*WIDTH){1'b0}};
      r_cnt    <= CNT_W'(WIDTH - 1);
      r_busy   <= 1'b1;
      r_done   <= 1'b0;
    end else if (r_busy) begin
      r_prod   <= r_prod + w_addend;
      r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
      r_cnt    <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end else begin
        r_done <= 1'b0;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign o_product = r_prod;
  assign o_done    = r_done;

endmodule

// File: rtl/seq_param_alu.sv
// ---------------------------------------------------------------------------
// seq_param_alu
// Registered WIDTH-bit ALU with valid/ready handshake on input and output.
// Single-cycle ops produce their result on the accept edge (latency 1); MUL
// runs through an iterative multiplier (latency WIDTH+1). The result stays
// in HOLD until the consumer takes it; a new op may be accepted in the same
// cycle the old result is taken, giving one result per clock.
// Ports:
//   Clk       clock, rising edge
//   Reset     synchronous active-high reset
//   InValid   Sel/A/B valid this cycle
//   InReady   block accepts an op this cycle
//   Sel       opcode (see alu_op_e); 12..15 reserved
//   A, B      operands; B is the shift amount for shifts
//   Q         registered result
//   Flags     registered {Z,N,C,V}
//   Illegal   result came from a reserved opcode
//   OutValid  Q/Flags/Illegal valid
//   OutReady  consumer takes the result this cycle
// ---------------------------------------------------------------------------
module seq_param_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OP_W  = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [OP_W-1:0]  Sel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [3:0]       Flags,
  output logic             Illegal,
  output logic             OutValid,
  input  logic             OutReady
);

  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};

  alu_state_e         r_state;
  logic [WIDTH-1:0]   r_q;
  logic [3:0]         r_flags;
  logic               r_illegal;
  logic               r_out_valid;

  alu_op_e            w_op;
  logic               w_in_ready;
  logic               w_accept;
  logic               w_mul_start;
  logic [2*WIDTH-1:0] w_product;
  logic               w_mul_done;
  logic [WIDTH-1:0]   w_mul_q;
  logic               w_mul_cv;
  logic [3:0]         w_mul_flags;

  logic [WIDTH-1:0]   w_add_b;
  logic [WIDTH:0]     w_sum_ext;
  logic [WIDTH-1:0]   w_diff;
  logic               w_sh_big;
  logic [WIDTH:0]     w_shl_ext;
  logic [WIDTH:0]     w_shr_ext;
  logic [WIDTH:0]     w_sar_ext;

  logic [WIDTH-1:0]   w_res_q;
  logic               w_res_c;
  logic               w_res_v;
  logic               w_res_ill;
  logic [3:0]         w_res_flags;

  assign w_op        = alu_op_e'(Sel[3:0]);
  // Ready when empty, or when the held result leaves this very cycle.
  assign w_in_ready  = (r_state == ST_IDLE) | ((r_state == ST_HOLD) & OutReady);
  assign w_accept    = InValid & w_in_ready;
  assign w_mul_start = w_accept & (w_op == OP_MUL);

  alu_shift_add_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .i_clk     (Clk),
    .i_reset   (Reset),
    .i_start   (w_mul_start),
    .i_a       (A),
    .i_b       (B),
    .o_product (w_product),
    .o_done    (w_mul_done)
  );

  assign w_mul_q     = w_product[WIDTH-1:0];
  assign w_mul_cv    = |w_product[2*WIDTH-1:WIDTH];
  assign w_mul_flags = pack_flags(w_mul_q == ZERO_W, w_mul_q[WIDTH-1], w_mul_cv, w_mul_cv);

  // INC reuses the adder with a constant second operand.
  assign w_add_b   = (w_op == OP_INC) ? ONE_W : B;
  assign w_sum_ext = {1'b0, A} + {1'b0, w_add_b};
  assign w_diff    = A - B;

  // One spare bit on the shift-out side catches the last bit shifted out.
  assign w_sh_big  = (B >= WIDTH_V);
  assign w_shl_ext = {1'b0, A} << B;
  assign w_shr_ext = {A, 1'b0} >> B;
  assign w_sar_ext = $signed({A, 1'b0}) >>> B;

  // Single-cycle result and C/V selection by opcode.
  always_comb begin
    w_res_q   = ZERO_W;
    w_res_c   = 1'b0;
    w_res_v   = 1'b0;
    w_res_ill = 1'b0;
    case (w_op)
      OP_ZERO: begin
        w_res_q = ZERO_W;
      end
      OP_ADD, OP_INC: begin
        w_res_q = w_sum_ext[WIDTH-1:0];
        w_res_c = w_sum_ext[WIDTH];
        w_res_v = (A[WIDTH-1] == w_add_b[WIDTH-1]) &
                  (w_sum_ext[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        w_res_q = w_diff;
        w_res_c = (A < B);
        w_res_v = (A[WIDTH-1] != B[WIDTH-1]) & (w_diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_PASSA: begin
        w_res_q = A;
      end
      OP_XOR: begin
        w_res_q = A ^ B;
      end
      OP_OR: begin
        w_res_q = A | B;
      end
      OP_AND: begin
        w_res_q = A & B;
      end
      OP_MUL: begin
        // Result arrives from the multiplier while BUSY.
        w_res_q = ZERO_W;
      end
      OP_SHL: begin
        if (w_sh_big) begin
          w_res_q = ZERO_W;
          w_res_c = 1'b0;
        end else begin
          w_res_q = w_shl_ext[WIDTH-1:0];
          w_res_c = w_shl_ext[WIDTH];
        end
      end
      OP_SHR: begin
        if (w_sh_big) begin
          w_res_q = ZERO_W;
          w_res_c = 1'b0;
        end else begin
          w_res_q = w_shr_ext[WIDTH:1];
          w_res_c = w_shr_ext[0];
        end
      end
      OP_SAR: begin
        if (w_sh_big) begin
          w_res_q = {WIDTH{A[WIDTH-1]}};
          w_res_c = 1'b0;
        end else begin
          w_res_q = w_sar_ext[WIDTH:1];
          w_res_c = w_sar_ext[0];
        end
      end
      default: begin
        w_res_q   = ZERO_W;
        w_res_ill = 1'b1;
      end
    endcase
  end

  assign w_res_flags = pack_flags(w_res_q == ZERO_W, w_res_q[WIDTH-1], w_res_c, w_res_v);

  // Handshake FSM and output registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= ST_IDLE;
      r_q         <= ZERO_W;
      r_flags     <= 4'b0000;
      r_illegal   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_HOLD: begin
          if (w_accept) begin
            if (w_op == OP_MUL) begin
              r_state     <= ST_BUSY;
              r_out_valid <= 1'b0;
            end else begin
              r_q         <= w_res_q;
              r_flags     <= w_res_flags;
              r_illegal   <= w_res_ill;
              r_out_valid <= 1'b1;
              r_state     <= ST_HOLD;
            end
          end else if ((r_state == ST_HOLD) && OutReady) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_out_valid <= r_out_valid;
          end
        end
        ST_BUSY: begin
          if (w_mul_done) begin
            r_q         <= w_mul_q;
            r_flags     <= w_mul_flags;
            r_illegal   <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= ST_HOLD;
          end else begin
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign InReady  = w_in_ready;
  assign Q        = r_q;
  assign Flags    = r_flags;
  assign Illegal  = r_illegal;
  assign OutValid = r_out_valid;

endmodule

// File: tb/tb_seq_param_alu.sv
module tb_seq_param_alu;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        InValid;
  logic        OutReady;
  logic [3:0]  Sel;
  logic [15:0] A;
  logic [15:0] B;

  logic        in_ready8, ill8, ov8;
  logic [7:0]  q8;
  logic [3:0]  f8;
  logic        in_ready16, ill16, ov16;
  logic [15:0] q16;
  logic [3:0]  f16;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  seq_param_alu #(.WIDTH(8), .OP_W(4)) dut8 (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(in_ready8),
    .Sel(Sel), .A(A[7:0]), .B(B[7:0]), .Q(q8), .Flags(f8),
    .Illegal(ill8), .OutValid(ov8), .OutReady(OutReady)
  );

  seq_param_alu #(.WIDTH(16), .OP_W(4)) dut16 (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(in_ready16),
    .Sel(Sel), .A(A), .B(B), .Q(q16), .Flags(f16),
    .Illegal(ill16), .OutValid(ov16), .OutReady(OutReady)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model, written at word level with an explicit width w.
  function automatic void model(input int w, input logic [3:0] op,
                                input logic [15:0] ai, input logic [15:0] bi,
                                output logic [15:0] q, output logic [3:0] f,
                                output logic ill);
    logic [31:0] mask, a, b, full;
    logic c, v, sa, sb, sq;
    int sh;
    mask = (32'd1 << w) - 32'd1;
    a = {16'd0, ai} & mask;
    b = {16'd0, bi} & mask;
    sh = int'(b);
    full = 32'd0; c = 1'b0; v = 1'b0; ill = 1'b0;
    case (op)
      4'd0: full = 32'd0;
      4'd1: begin full = a + b; c = full[w]; end
      4'd2: begin full = a - b; c = (a < b); end
      4'd3: full = a;
      4'd4: full = a ^ b;
      4'd5: full = a | b;
      4'd6: full = a & b;
      4'd7: begin full = a + 32'd1; c = full[w]; end
      4'd8: begin full = a * b; c = ((full >> w) != 32'd0); v = c; end
      4'd9: begin
        full = (sh >= w) ? 32'd0 : (a << sh);
        c = (sh > 0 && sh < w) ? a[w - sh] : 1'b0;
      end
      4'd10: begin
        full = (sh >= w) ? 32'd0 : (a >> sh);
        c = (sh > 0 && sh < w) ? a[sh - 1] : 1'b0;
      end
      4'd11: begin
        if (sh >= w) full = a[w-1] ? mask : 32'd0;
        else full = (a >> sh) | (a[w-1] ? (mask & ~(mask >> sh)) : 32'd0);
        c = (sh > 0 && sh < w) ? a[sh - 1] : 1'b0;
      end
      default: ill = 1'b1;
    endcase
    q  = 16'(full & mask);
    sa = a[w-1]; sb = b[w-1]; sq = q[w-1];
    if (op == 4'd1) v = (sa == sb) && (sq != sa);
    if (op == 4'd7) v = !sa && sq;
    if (op == 4'd2) v = (sa != sb) && (sq != sa);
    f = {(q == 16'd0), sq, c, v};
  endfunction

  // Issue one op on the 8-bit unit from IDLE, check result/latency, then drain.
  task automatic run_dir(input string tag, input logic [3:0] sel, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] eq, input logic [3:0] ef,
                         input logic eill, input int elat);
    int lat;
    Sel = sel; A = {8'h00, a}; B = {8'h00, b}; InValid = 1'b1; OutReady = 1'b0;
    check_eq({tag, "_inrdy"}, in_ready8, 1);
    @(posedge Clk); #1;
    InValid = 1'b0;
    lat = 1;
    if (elat > 1) check_eq({tag, "_busy_inrdy"}, in_ready8, 0);
    while (!ov8 && lat < 40) begin
      @(posedge Clk); #1;
      lat++;
    end
    check_eq({tag, "_lat"}, lat, elat);
    check_eq({tag, "_q"}, q8, eq);
    check_eq({tag, "_flags"}, f8, ef);
    check_eq({tag, "_ill"}, ill8, eill);
    OutReady = 1'b1;
    @(posedge Clk); #1;
    OutReady = 1'b0;
    check_eq({tag, "_drain"}, ov8, 0);
  endtask

  initial begin
    logic [3:0]  op;
    logic [15:0] a16, b16, eq16;
    logic [3:0]  ef;
    logic        eill;
    int          cyc;
    int          seen;

    Reset = 1'b1; InValid = 1'b0; OutReady = 1'b0; Sel = 4'd0; A = 16'd0; B = 16'd0;
    repeat (2) @(posedge Clk);
    #1;
    check_eq("rst_q", q8, 0);
    check_eq("rst_flags", f8, 0);
    check_eq("rst_ill", ill8, 0);
    check_eq("rst_ov", ov8, 0);
    check_eq("rst_inrdy", in_ready8, 1);
    Reset = 1'b0;
    @(posedge Clk); #1;

    // Directed vectors, WIDTH=8; flags are {Z,N,C,V}.
    run_dir("add_f0_20",  4'd1,  8'hF0, 8'h20, 8'h10, 4'b0010, 1'b0, 1);
    run_dir("sub_80_01",  4'd2,  8'h80, 8'h01, 8'h7F, 4'b0001, 1'b0, 1);
    run_dir("sub_05_05",  4'd2,  8'h05, 8'h05, 8'h00, 4'b1000, 1'b0, 1);
    run_dir("mul_0d_0b",  4'd8,  8'h0D, 8'h0B, 8'h8F, 4'b0100, 1'b0, 9);
    run_dir("mul_14_14",  4'd8,  8'h14, 8'h14, 8'h90, 4'b0111, 1'b0, 9);
    run_dir("sar_90_2",   4'd11, 8'h90, 8'h02, 8'hE4, 4'b0100, 1'b0, 1);
    run_dir("shl_81_1",   4'd9,  8'h81, 8'h01, 8'h02, 4'b0010, 1'b0, 1);
    run_dir("shr_a5_9",   4'd10, 8'hA5, 8'h09, 8'h00, 4'b1000, 1'b0, 1);
    run_dir("sar_90_9",   4'd11, 8'h90, 8'h09, 8'hFF, 4'b0100, 1'b0, 1);
    run_dir("rsv_13",     4'd13, 8'h12, 8'h34, 8'h00, 4'b1000, 1'b1, 1);
    run_dir("inc_ff",     4'd7,  8'hFF, 8'h00, 8'h00, 4'b1010, 1'b0, 1);
    run_dir("inc_7f",     4'd7,  8'h7F, 8'h00, 8'h80, 4'b0101, 1'b0, 1);
    run_dir("xor_f0_3c",  4'd4,  8'hF0, 8'h3C, 8'hCC, 4'b0100, 1'b0, 1);
    run_dir("shr_a5_3",   4'd10, 8'hA5, 8'h03, 8'h14, 4'b0010, 1'b0, 1);

    // Stall in HOLD, then stream one op per cycle.
    Reset = 1'b1; @(posedge Clk); #1; Reset = 1'b0;
    Sel = 4'd1; A = 16'h0001; B = 16'h0002; InValid = 1'b1; OutReady = 1'b0;
    @(posedge Clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      check_eq("hold_q", q8, 8'h03);
      check_eq("hold_ov", ov8, 1);
      check_eq("hold_inrdy", in_ready8, 0);
    end
    OutReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      A = 16'(i); B = 16'h0010;
      @(posedge Clk); #1;
      check_eq("stream_q", q8, 8'(i + 16));
      check_eq("stream_ov", ov8, 1);
    end
    InValid = 1'b0;
    @(posedge Clk); #1;
    check_eq("stream_end_ov", ov8, 0);
    OutReady = 1'b0;

    // Reset during a multiply: no result must appear afterwards.
    Sel = 4'd8; A = 16'h0003; B = 16'h0005; InValid = 1'b1;
    @(posedge Clk); #1;
    InValid = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    check_eq("rstmul_ov", ov8, 0);
    check_eq("rstmul_inrdy", in_ready8, 1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge Clk); #1;
      if (ov8) seen++;
    end
    check_eq("rstmul_no_result", seen, 0);

    // Random ops on both widths against the model.
    Reset = 1'b1; @(posedge Clk); #1; Reset = 1'b0;
    for (int i = 0; i < 500; i++) begin
      op  = 4'($urandom_range(0, 15));
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      if (op >= 4'd9 && op <= 4'd11 && $urandom_range(0, 3) != 0)
        b16 = 16'($urandom_range(0, 17));
      Sel = op; A = a16; B = b16; InValid = 1'b1; OutReady = 1'b0;
      @(posedge Clk); #1;
      InValid = 1'b0;
      cyc = 0;
      while (!(ov8 && ov16) && cyc < 40) begin
        @(posedge Clk); #1;
        cyc++;
      end
      check_eq("rnd_timeout", ov8 & ov16, 1);
      model(8, op, a16, b16, eq16, ef, eill);
      check_eq("rnd8_q", q8, eq16[7:0]);
      check_eq("rnd8_flags", f8, ef);
      check_eq("rnd8_ill", ill8, eill);
      model(16, op, a16, b16, eq16, ef, eill);
      check_eq("rnd16_q", q16, eq16);
      check_eq("rnd16_flags", f16, ef);
      check_eq("rnd16_ill", ill16, eill);
      OutReady = 1'b1;
      @(posedge Clk); #1;
      OutReady = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
